// File: rtl/uart_rx_monitor_if.sv
// Serial line and received-byte handshake bundle for uart_rx_monitor.
// master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_monitor_if;
  logic       io_rxd;
  logic [7:0] io_data;
  logic       io_valid;
  logic       io_ready;
  logic       io_frameErr;
  logic       io_overrun;
  logic       io_parityErr;

  modport master (
    input  io_rxd,
    input  io_ready,
    output io_data,
    output io_valid,
    output io_frameErr,
    output io_overrun,
    output io_parityErr
  );

  modport slave (
    output io_rxd,
    output io_ready,
    input  io_data,
    input  io_valid,
    input  io_frameErr,
    input  io_overrun,
    input  io_parityErr
  );
endinterface

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with valid/ready byte output and frame/overrun error strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity-error strobe.
module uart_rx_monitor #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic              io_mainClk,
  input  logic              io_reset,
  uart_rx_monitor_if.master bus
);

  localparam int CPB  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx_monitor: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
  end

  logic          rx_meta;
  logic          rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          pend;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_q;
  logic          overrun_q;
  logic          parity_q;
`ifdef UART_RX_PARITY_EN
  logic          par_bad;
`endif

  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      pend      <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      frame_q   <= 1'b0;
      overrun_q <= 1'b0;
      parity_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      rx_meta   <= bus.io_rxd;
      rxs       <= rx_meta;
      frame_q   <= 1'b0;
      overrun_q <= 1'b0;
      parity_q  <= 1'b0;
      pend      <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxs) state <= S_START;
        end
        S_START: begin
          if (cnt == CNT_HALF_END) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_BIT_END) begin
            cnt            <= '0;
            shift[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_BIT_END) begin
            cnt     <= '0;
            par_bad <= (rxs != ^shift);
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (cnt == CNT_BIT_END) begin
            cnt <= '0;
            if (rxs) begin
              pend  <= 1'b1;
              state <= S_IDLE;
            end else begin
              frame_q <= 1'b1;
              state   <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rxs) state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase

      // Handshake clears first; a byte completing in the same cycle reloads.
      // shift is stable while pend is set because the FSM cannot reach DATA yet.
      if (valid_q && bus.io_ready) valid_q <= 1'b0;
      if (pend) begin
        if (!valid_q || bus.io_ready) begin
          data_q  <= shift;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        parity_q <= par_bad;
`endif
      end
    end
  end

  assign bus.io_data      = data_q;
  assign bus.io_valid     = valid_q;
  assign bus.io_frameErr  = frame_q;
  assign bus.io_overrun   = overrun_q;
  assign bus.io_parityErr = parity_q;

endmodule
